spi_xfer_sched: RTL and testbench
=================================

Name: spi_xfer_sched

Overview:
- Round-robin scheduler that shares one Wishbone SPI master core among NREQ local requesters.
- For each granted request it drives a fixed Wishbone master access sequence into the core: divider, slave select, TX word, CTRL config, CTRL+GO, poll GO, RX read.
- It then returns the received word to the requester with a one-cycle done pulse.
- It sits between client logic and the SPI core's slave port; it is the only master on that port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DIVIDER, 32'd4, value written to the core divider register on every transfer.
- POLL_MAX, 16'd1000, maximum CTRL poll reads before timeout.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  NREQ  request per requester; level, held until its done_o.
- ss_idx_i  in  NREQ*5  per-requester slave index 0..31, packed with requester k at [5k+4:5k].
- len_i  in  NREQ*5  per-requester char length; 0 encodes 32 bits.
- mode_i  in  NREQ*3  per-requester {lsb, tx_negedge, rx_negedge}.
- tx_dat_i  in  NREQ*32  per-requester TX word.
- gnt_o  out  NREQ  one-hot, held for the whole transaction.
- done_o  out  NREQ  one-cycle pulse at transaction end.
- err_o  out  1  one-cycle pulse with done_o on poll timeout.
- rx_dat_o  out  32  received word; valid in the done_o cycle, held until the next done.
- m_adr_o  out  5  byte address to the core.
- m_dat_o  out  32  write data.
- m_dat_i  in  32  read data.
- m_sel_o  out  4  byte selects; always 4'hF.
- m_we_o  out  1  write enable.
- m_stb_o  out  1  strobe.
- m_cyc_o  out  1  cycle.
- m_ack_i  in  1  acknowledge.

Behaviour:
- Core register map (byte address):
  - TX0/RX0 = 0x00, CTRL = 0x10, DIVIDE = 0x14, SS = 0x18.
  - CTRL bits: [6:0] char_len, 8 GO, 9 RX_NEG, 10 TX_NEG, 11 LSB, 12 IE, 13 ASS.
- Reset values: all outputs 0; m_sel_o is 4'hF out of reset; state IDLE; round-robin pointer = 0. Reset mid-transaction drops m_cyc_o/m_stb_o asynchronously and abandons the transfer with no done_o.
- Wishbone access rule:
  - m_cyc_o = m_stb_o, both registered.
  - They are asserted on entry to an access state and held until the first cycle m_ack_i = 1.
  - They deassert on the next edge, and the state advances on that same edge.
  - One idle cycle (stb low) always follows each access.
  - No access is issued in IDLE.
- Arbitration (IDLE only):
  - Search req_i starting at index ptr+1 mod NREQ; the first set bit wins.
  - On a win: gnt_o is set, ptr = winner, and that requester's ss_idx/len/mode/tx are latched.
  - Grant issues one cycle after req_i is seen.
  - req_i dropping mid-transaction is ignored; the transaction completes and done_o still pulses.
- States and accesses:
  - IDLE -> W_DIV: write DIVIDER to 0x14.
  - W_DIV -> W_SS: write 32'b1 << ss_idx to 0x18.
  - W_SS -> W_TX: write tx word to 0x00.
  - W_TX -> W_CFG: write CTRL to 0x10 with bit13 = 1, bit12 = 0, bits[11:9] = mode, [6:0] = {2'b0, len}, GO = 0.
  - W_CFG -> W_GO: same CTRL word with bit 8 = 1.
  - W_GO -> POLL: read 0x10.
    - If m_dat_i[8] = 1 and poll count < POLL_MAX: increment count and reread after the idle cycle.
    - If m_dat_i[8] = 0: go to R_RX.
    - Timeout (count reaches POLL_MAX with GO still 1) -> DONE with err.
  - R_RX: read 0x00 and capture m_dat_i into rx_dat_o -> DONE.
  - DONE: single cycle; pulse done_o[winner] (and err_o on timeout; rx_dat_o is then 0); clear gnt_o -> IDLE.
- The poll counter is 16-bit and is cleared on each grant.
- A back-to-back request from another requester can be granted in the cycle after DONE.

Test Plan:
- Single request: req_i = 4'b0001, ss_idx = 2, len = 8, tx = 0xA5, core model loops MOSI->MISO. Required: write sequence 0x14 = 4, 0x18 = 0x4, 0x00 = 0xA5, 0x10 = 0x2008, 0x10 = 0x2108; then polls; then read 0x00; then done_o = 4'b0001 with rx_dat_o = 0xA5.
- Round robin: req_i = 4'b1111 held continuously. Required: grants in order 1, 2, 3, 0, 1; each gnt_o is one-hot and held until its done.
- Mode/length: len = 0, mode = 3'b111, tx = 0xDEADBEEF. Required: CTRL GO write = 0x2F00; rx_dat_o = 0xDEADBEEF with loopback.
- Timeout: core model holds GO = 1 for all reads, POLL_MAX = 16. Required: exactly 16 reads of 0x10, then done_o with err_o = 1 and rx_dat_o = 0.
- Reset mid-transfer: assert wb_rst_i during W_TX. Required: m_stb_o/m_cyc_o/gnt_o go to 0 immediately with no done_o. After release, a request for requester 1 is granted first (ptr = 0).
- Ack latency: core acks 1 and 3 cycles after stb. Required: m_stb_o is held until ack and drops the next cycle, with exactly one idle cycle between accesses.

Source files
------------

// File: rtl/spi_xfer_sched.sv
// Round-robin front end that serialises requester transfers onto a single
// Wishbone SPI master core: program, start, poll, read back, report.
module spi_xfer_sched #(
    parameter int          NREQ     = 4,
    parameter logic [31:0] DIVIDER  = 32'd4,
    parameter logic [15:0] POLL_MAX = 16'd1000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*5-1:0]  ss_idx_i,
    input  logic [NREQ*5-1:0]  len_i,
    input  logic [NREQ*3-1:0]  mode_i,
    input  logic [NREQ*32-1:0] tx_dat_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               err_o,
    output logic [31:0]        rx_dat_o,
    output logic [4:0]         m_adr_o,
    output logic [31:0]        m_dat_o,
    input  logic [31:0]        m_dat_i,
    output logic [3:0]         m_sel_o,
    output logic               m_we_o,
    output logic               m_stb_o,
    output logic               m_cyc_o,
    input  logic               m_ack_i
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [3:0] {
        IDLE, W_DIV, W_SS, W_TX, W_CFG, W_GO, POLL, R_RX, DONE
    } state_t;

    state_t         state_q, state_d;
    logic           stb_q, stb_d;
    logic           gap_q, gap_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    rx_q, rx_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [4:0]     ss_q, ss_d;
    logic [4:0]     len_q, len_d;
    logic [2:0]     mode_q, mode_d;
    logic [31:0]    tx_q, tx_d;

    logic           win_found;
    logic [PW-1:0]  win_idx;
    int             idx;
    logic [31:0]    cfg_word;
    logic [15:0]    cnt_inc;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // ASS set, IE clear; GO is or'ed in for the start write.
    assign cfg_word = {18'b0, 1'b1, 1'b0, mode_q, 1'b0, 1'b0, 2'b00, len_q};
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        m_adr_o = 5'h00;
        m_dat_o = 32'h0;
        m_we_o  = 1'b0;
        case (state_q)
            W_DIV: begin m_adr_o = 5'h14; m_dat_o = DIVIDER;        m_we_o = 1'b1; end
            W_SS:  begin m_adr_o = 5'h18; m_dat_o = 32'd1 << ss_q;  m_we_o = 1'b1; end
            W_TX:  begin m_adr_o = 5'h00; m_dat_o = tx_q;           m_we_o = 1'b1; end
            W_CFG: begin m_adr_o = 5'h10; m_dat_o = cfg_word;       m_we_o = 1'b1; end
            W_GO:  begin m_adr_o = 5'h10; m_dat_o = cfg_word | 32'h100; m_we_o = 1'b1; end
            POLL:  m_adr_o = 5'h10;
            R_RX:  m_adr_o = 5'h00;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        ss_d    = ss_q;
        len_d   = len_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d    = '0;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d    = win_idx;
                    ss_d     = ss_idx_i[int'(win_idx)*5 +: 5];
                    len_d    = len_i[int'(win_idx)*5 +: 5];
                    mode_d   = mode_i[int'(win_idx)*3 +: 3];
                    tx_d     = tx_dat_i[int'(win_idx)*32 +: 32];
                    cnt_d    = 16'd0;
                    stb_d    = 1'b1;
                    gap_d    = 1'b0;
                    state_d  = W_DIV;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                if (gap_q) begin
                    stb_d = 1'b1;
                    gap_d = 1'b0;
                end else if (stb_q && m_ack_i) begin
                    // Ack closes the access; the next state opens after one idle cycle.
                    stb_d = 1'b0;
                    gap_d = 1'b1;
                    case (state_q)
                        W_DIV: state_d = W_SS;
                        W_SS:  state_d = W_TX;
                        W_TX:  state_d = W_CFG;
                        W_CFG: state_d = W_GO;
                        W_GO:  state_d = POLL;
                        POLL: begin
                            if (!m_dat_i[8]) begin
                                state_d = R_RX;
                            end else if (cnt_inc >= POLL_MAX) begin
                                cnt_d   = cnt_inc;
                                state_d = DONE;
                                gap_d   = 1'b0;
                                done_d  = gnt_q;
                                err_d   = 1'b1;
                                rx_d    = 32'h0;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                        R_RX: begin
                            rx_d    = m_dat_i;
                            state_d = DONE;
                            gap_d   = 1'b0;
                            done_d  = gnt_q;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            gap_q   <= 1'b0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rx_q    <= 32'h0;
            cnt_q   <= 16'd0;
            ss_q    <= 5'd0;
            len_q   <= 5'd0;
            mode_q  <= 3'd0;
            tx_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            ss_q    <= ss_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rx_dat_o = rx_q;
    assign m_stb_o  = stb_q;
    assign m_cyc_o  = stb_q;
    assign m_sel_o  = 4'hF;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a loopback SPI core model and a
// Wishbone handshake monitor.
module tb_spi_xfer_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [19:0]  ss_idx = '0;
    logic [19:0]  len = '0;
    logic [11:0]  mode = '0;
    logic [127:0] tx = '0;
    logic [3:0]   gnt_o, done_o;
    logic         err_o;
    logic [31:0]  rx_dat_o;
    logic [4:0]   m_adr_o;
    logic [31:0]  m_dat_o;
    logic [31:0]  m_dat_i = '0;
    logic [3:0]   m_sel_o;
    logic         m_we_o, m_stb_o, m_cyc_o;
    logic         m_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;

    // core model state
    int          ack_lat = 0;
    int          busy_polls = 2;
    bit          hold_go = 0;
    int          busy = 0;
    logic [31:0] ctrl_r = '0;
    logic [31:0] tx_r = '0;
    logic [4:0]  log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];

    spi_xfer_sched #(.NREQ(4), .DIVIDER(32'd4), .POLL_MAX(16'd16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .ss_idx_i(ss_idx),
        .len_i(len), .mode_i(mode), .tx_dat_i(tx), .gnt_o(gnt_o),
        .done_o(done_o), .err_o(err_o), .rx_dat_o(rx_dat_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_sel_o(m_sel_o), .m_we_o(m_we_o), .m_stb_o(m_stb_o),
        .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i)
    );

    always #5 clk = ~clk;

    // Slave model plus handshake monitor, evaluated on the falling edge.
    initial begin
        int lat = 0;
        int stb_run = 0;
        int low_run = 0;
        logic prev_stb = 0;
        logic [3:0] prev_gnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ack_i = 0; m_dat_i = '0; lat = 0; stb_run = 0;
                low_run = 0; prev_stb = 0; prev_gnt = 0; busy = 0;
                continue;
            end
            if (m_cyc_o !== m_stb_o) proto_err++;
            if (m_sel_o !== 4'hF) proto_err++;
            if (gnt_o != 0 && $countones(gnt_o) != 1) proto_err++;
            if (prev_gnt != 0 && gnt_o != 0 && gnt_o != prev_gnt) proto_err++;
            if (done_o != 0 && done_o !== gnt_o) proto_err++;
            if (err_o && done_o == 0) proto_err++;
            if (m_stb_o && gnt_o == 0) proto_err++;
            if (m_stb_o) begin
                if (!prev_stb && prev_gnt != 0 && low_run != 1) proto_err++;
                low_run = 0;
                stb_run++;
            end else begin
                if (prev_stb && stb_run != ack_lat + 1) proto_err++;
                stb_run = 0;
                low_run++;
            end
            if (m_ack_i) begin
                m_ack_i = 0;
                m_dat_i = '0;
                if (m_stb_o) proto_err++;
            end else if (m_stb_o) begin
                if (lat == ack_lat) begin
                    lat = 0;
                    m_ack_i = 1;
                    if (m_we_o) begin
                        if (m_adr_o == 5'h10) begin
                            ctrl_r = m_dat_o;
                            if (m_dat_o[8]) busy = busy_polls;
                        end else if (m_adr_o == 5'h00) begin
                            tx_r = m_dat_o;
                        end
                        log_dat.push_back(m_dat_o);
                    end else begin
                        if (m_adr_o == 5'h10) begin
                            if (hold_go || busy > 0) begin
                                m_dat_i = ctrl_r | 32'h100;
                                if (busy > 0) busy--;
                            end else begin
                                m_dat_i = ctrl_r & ~32'h100;
                            end
                        end else begin
                            m_dat_i = tx_r;
                        end
                        log_dat.push_back(m_dat_i);
                    end
                    log_adr.push_back(m_adr_o);
                    log_we.push_back(m_we_o);
                end else begin
                    lat++;
                end
            end
            prev_stb = m_stb_o;
            prev_gnt = gnt_o;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int k, input logic [4:0] s, input logic [4:0] l,
                           input logic [2:0] md, input logic [31:0] t);
        ss_idx[5*k +: 5] = s;
        len[5*k +: 5]    = l;
        mode[3*k +: 3]   = md;
        tx[32*k +: 32]   = t;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_o != 0) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic clear_log();
        log_adr.delete(); log_dat.delete(); log_we.delete();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if (gnt_o !== 4'b0)  begin errors++; $display("FAIL reset_gnt got %h want 0", gnt_o); end
        checks++; if (done_o !== 4'b0) begin errors++; $display("FAIL reset_done got %h want 0", done_o); end
        checks++; if (m_stb_o !== 1'b0 || m_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %b%b want 00", m_stb_o, m_cyc_o); end
        checks++; if (m_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got %h want f", m_sel_o); end
        checks++; if (err_o !== 1'b0 || rx_dat_o !== 32'h0) begin errors++; $display("FAIL reset_err_rx got %b %h want 0 0", err_o, rx_dat_o); end
        checks++; if (m_we_o !== 1'b0 || m_adr_o !== 5'h0) begin errors++; $display("FAIL reset_bus got we=%b adr=%h want 0 0", m_we_o, m_adr_o); end
        rst = 0;
        $display("reset: gnt=%h done=%h stb=%b sel=%h", gnt_o, done_o, m_stb_o, m_sel_o);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bit ok;
        busy_polls = 1;
        for (int k = 0; k < 4; k++) set_req(k, 5'(k), 5'd8, 3'b000, 32'h10 + k);
        @(negedge clk);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(ok);
            if (n == 4) req = 4'b0000;
            checks++;
            if (!ok) begin errors++; $display("FAIL rr_timeout xfer %0d got no done want done", n); end
            else if (done_o !== exp_order[n] || gnt_o !== exp_order[n]) begin
                errors++; $display("FAIL rr_order xfer %0d got done=%b gnt=%b want %b", n, done_o, gnt_o, exp_order[n]);
            end
            $display("rr xfer %0d: done=%b rx=%h", n, done_o, rx_dat_o);
        end
        repeat (2) @(negedge clk);
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL rr_protocol got %0d violations want 0", proto_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 0;
        clear_log();
        set_req(3, 5'd1, 5'd8, 3'b000, 32'h33);
        set_req(0, 5'd0, 5'd8, 3'b000, 32'h44);
        set_req(1, 5'd1, 5'd8, 3'b000, 32'h55);
        req = 4'b1000;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (m_stb_o && m_we_o && m_adr_o == 5'h00) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_wtx got no TX write want TX write"); end
        rst = 1;
        #1;
        checks++; if (m_stb_o !== 1'b0 || m_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_stb got %b%b want 00", m_stb_o, m_cyc_o); end
        checks++; if (gnt_o !== 4'b0) begin errors++; $display("FAIL rstmid_gnt got %b want 0000", gnt_o); end
        req = 4'b0011;
        repeat (3) @(negedge clk);
        checks++; if (done_o !== 4'b0) begin errors++; $display("FAIL rstmid_nodone got %b want 0000", done_o); end
        rst = 0;
        wait_done(ok);
        req = 4'b0001;
        checks++; if (!ok || done_o !== 4'b0010) begin errors++; $display("FAIL rstmid_first got %b want 0010", done_o); end
        $display("reset mid: first done after reset=%b rx=%h", done_o, rx_dat_o);
        wait_done(ok);
        req = 4'b0000;
        checks++; if (!ok || done_o !== 4'b0001 || rx_dat_o !== 32'h44) begin errors++; $display("FAIL rstmid_second got %b rx=%h want 0001 rx=44", done_o, rx_dat_o); end
        repeat (2) @(negedge clk);
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL rstmid_protocol got %0d violations want 0", proto_err); end
    endtask

    task automatic test_mode();
        bit ok;
        busy_polls = 2;
        clear_log();
        set_req(2, 5'd31, 5'd0, 3'b111, 32'hDEADBEEF);
        req = 4'b0100;
        wait_done(ok);
        req = 4'b0000;
        checks++; if (!ok || done_o !== 4'b0100) begin errors++; $display("FAIL mode_done got %b want 0100", done_o); end
        checks++; if (rx_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mode_rx got %h want deadbeef", rx_dat_o); end
        checks++; if (log_dat.size() < 5 || log_dat[1] !== 32'h80000000) begin errors++; $display("FAIL mode_ss got %h want 80000000", log_dat.size() > 1 ? log_dat[1] : 32'hx); end
        checks++; if (log_dat.size() < 5 || log_dat[3] !== 32'h2E00) begin errors++; $display("FAIL mode_cfg got %h want 2e00", log_dat.size() > 3 ? log_dat[3] : 32'hx); end
        checks++; if (log_dat.size() < 5 || log_dat[4] !== 32'h2F00) begin errors++; $display("FAIL mode_go got %h want 2f00", log_dat.size() > 4 ? log_dat[4] : 32'hx); end
        $display("mode: go_word=%h rx=%h", log_dat.size() > 4 ? log_dat[4] : 32'hx, rx_dat_o);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [4:0]  e_adr [9] = '{5'h14, 5'h18, 5'h00, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00};
        logic [31:0] e_dat [9] = '{32'h4, 32'h4, 32'hA5, 32'h2008, 32'h2108, 32'h2108, 32'h2108, 32'h2008, 32'hA5};
        logic        e_we  [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        bit ok;
        busy_polls = 2;
        clear_log();
        set_req(0, 5'd2, 5'd8, 3'b000, 32'hA5);
        req = 4'b0001;
        wait_done(ok);
        req = 4'b0000;
        checks++; if (!ok || done_o !== 4'b0001) begin errors++; $display("FAIL single_done got %b want 0001", done_o); end
        checks++; if (rx_dat_o !== 32'hA5 || err_o !== 1'b0) begin errors++; $display("FAIL single_rx got rx=%h err=%b want a5 0", rx_dat_o, err_o); end
        checks++; if (log_adr.size() != 9) begin errors++; $display("FAIL single_count got %0d accesses want 9", log_adr.size()); end
        for (int i = 0; i < 9 && i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[i] !== e_adr[i] || log_dat[i] !== e_dat[i] || log_we[i] !== e_we[i]) begin
                errors++;
                $display("FAIL single_access %0d got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                         i, log_adr[i], log_dat[i], log_we[i], e_adr[i], e_dat[i], e_we[i]);
            end
        end
        $display("single: accesses=%0d done=%b rx=%h", log_adr.size(), done_o, rx_dat_o);
        @(negedge clk);
        checks++; if (done_o !== 4'b0 || rx_dat_o !== 32'hA5) begin errors++; $display("FAIL single_pulse got done=%b rx=%h want 0000 a5", done_o, rx_dat_o); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int polls = 0;
        int rx_reads = 0;
        hold_go = 1;
        clear_log();
        set_req(3, 5'd0, 5'd16, 3'b000, 32'h1234);
        req = 4'b1000;
        wait_done(ok);
        req = 4'b0000;
        for (int i = 0; i < log_adr.size(); i++) begin
            if (!log_we[i] && log_adr[i] == 5'h10) polls++;
            if (!log_we[i] && log_adr[i] == 5'h00) rx_reads++;
        end
        checks++; if (!ok || done_o !== 4'b1000 || err_o !== 1'b1) begin errors++; $display("FAIL timeout_done got done=%b err=%b want 1000 1", done_o, err_o); end
        checks++; if (rx_dat_o !== 32'h0) begin errors++; $display("FAIL timeout_rx got %h want 0", rx_dat_o); end
        checks++; if (polls != 16) begin errors++; $display("FAIL timeout_polls got %0d want 16", polls); end
        checks++; if (rx_reads != 0) begin errors++; $display("FAIL timeout_rxread got %0d want 0", rx_reads); end
        $display("timeout: polls=%0d done=%b err=%b rx=%h", polls, done_o, err_o, rx_dat_o);
        @(negedge clk);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL timeout_errpulse got %b want 0", err_o); end
        hold_go = 0;
        @(negedge clk);
    endtask

    task automatic test_ack_latency();
        int lats [2] = '{3, 1};
        bit ok;
        busy_polls = 1;
        for (int n = 0; n < 2; n++) begin
            ack_lat = lats[n];
            clear_log();
            set_req(1, 5'd4, 5'd8, 3'b001, 32'h5A + n);
            req = 4'b0010;
            wait_done(ok);
            req = 4'b0000;
            checks++; if (!ok || done_o !== 4'b0010 || rx_dat_o !== 32'h5A + n) begin errors++; $display("FAIL acklat%0d_done got %b rx=%h want 0010 rx=%h", lats[n], done_o, rx_dat_o, 32'h5A + n); end
            checks++; if (log_adr.size() != 8) begin errors++; $display("FAIL acklat%0d_count got %0d want 8", lats[n], log_adr.size()); end
            checks++; if (proto_err !== 0) begin errors++; $display("FAIL acklat%0d_protocol got %0d violations want 0", lats[n], proto_err); end
            $display("ack latency %0d: accesses=%0d rx=%h", lats[n], log_adr.size(), rx_dat_o);
            repeat (2) @(negedge clk);
        end
        ack_lat = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_reset_mid();
        test_mode();
        test_single();
        test_timeout();
        test_ack_latency();
        checks++; if (proto_err !== 0) begin errors++; $display("FAIL final_protocol got %0d violations want 0", proto_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
